// File: rtl/gpio_uart_tx_pkg.sv
// Shared definitions for the GPIO-to-UART logger: FSM states, 8N1 frame constants
// and the baud divider helper.
package gpio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Truncating divide: the bit period is rounded down to whole clock cycles.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/gpio_uart_tx_if.sv
// Bus between the MIPS GPIO side (master) and the UART logger (slave).
interface gpio_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    gpio_i;
    logic          tx_o;
    logic          busy_o;
    logic          overflow_o;
    logic [LW-1:0] level_o;

    modport master (
        output gpio_i,
        input  tx_o,
        input  busy_o,
        input  overflow_o,
        input  level_o
    );

    modport slave (
        input  gpio_i,
        output tx_o,
        output busy_o,
        output overflow_o,
        output level_o
    );

endinterface

// File: rtl/gpio_uart_tx_sync_fifo.sv
// Small single-clock FIFO; a push while full is accepted only when a pop frees
// a slot on the same edge.
module gpio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gpio_uart_tx.sv
// Logs every change of the GPIO byte as an 8N1 UART frame, LSB first, buffering
// bursts of changes in a small FIFO.
module gpio_uart_tx
    import gpio_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    gpio_uart_tx_if.slave bus
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    sample_q;
    logic [7:0]    last_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [7:0]    head;
    logic [7:0]    shreg;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          bit_done;
    tx_state_t     state;
    logic          tx_q;
    logic          busy_q;
    logic          overflow_q;

    assign push     = (sample_q != last_q);
    assign pop      = (state == IDLE) && !empty;
    assign bit_done = (cnt == CW'(DIV - 1));

    gpio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sample_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // last_q tracks every change, even one the FIFO had to drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q   <= 8'h00;
            last_q     <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            sample_q <= bus.gpio_i;
            if (push) begin
                last_q <= sample_q;
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // The line is driven from the current state, so tx lags the state by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= 8'h00;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state != IDLE) || (level != '0);
            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    cnt  <= '0;
                    if (pop) begin
                        shreg <= head;
                        state <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_done) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    tx_q <= shreg[0];
                    if (bit_done) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_o       = tx_q;
    assign bus.busy_o     = busy_q;
    assign bus.overflow_o = overflow_q;
    assign bus.level_o    = level;

endmodule
